sysid_reader_master: RTL

Avalon-MM master that reads the system-ID slave at power-up or on request. It reads the ID word (address 0) and then the timestamp word (address 1). It compares both against build-time expected values and reports match and timeout status to the boot and health logic. It sits on the same control interconnect as the sysid slave and drives that slave's one-bit address space.

---
 rtl/sysid_pkg.sv | 27 ++
 rtl/sysid_stall_timer.sv | 45 ++++
 rtl/sysid_reader_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// ---------------------------------------------------------------------------
// sysid_pkg
// Shared types and constants for the system-ID reader master.
//   sysid_rd_state_t : read sequence FSM states
//   SYSID_ADDR_ID    : word address of the ID register
//   SYSID_ADDR_TS    : word address of the timestamp register
//   SYSID_DATA_W     : Avalon data width
//   SYSID_CNT_W      : width of the shared stall/latency counter
// ---------------------------------------------------------------------------
package sysid_pkg;

   localparam int SYSID_DATA_W = 32;
   localparam int SYSID_CNT_W  = 16;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      REQ_ID,
      LAT_ID,
      REQ_TS,
      LAT_TS,
      FIN
   } sysid_rd_state_t;

endpackage : sysid_pkg

// File: rtl/sysid_stall_timer.sv
// ---------------------------------------------------------------------------
// sysid_stall_timer
// Loadable up-counter with clear, increment and terminal-count compare.
// Shared between the read-latency count and the waitrequest stall count,
// which are never active in the same cycle.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : force the count to zero (highest priority)
//   load           : load load_value into the count
//   load_value     : value used by load
//   incr           : increment the count by one
//   terminal       : terminal count to compare against
//   hit            : count currently equals terminal
// ---------------------------------------------------------------------------
module sysid_stall_timer
   import sysid_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   load,
   input  logic [SYSID_CNT_W-1:0] load_value,
   input  logic                   incr,
   input  logic [SYSID_CNT_W-1:0] terminal,
   output logic                   hit
);

   logic [SYSID_CNT_W-1:0] count_q;

   // Clear wins over load, load wins over increment.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (incr) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign hit = (count_q == terminal);

endmodule : sysid_stall_timer

// File: rtl/sysid_reader_master.sv
// ---------------------------------------------------------------------------
// sysid_reader_master
// Avalon-MM master that reads the system-ID slave (ID word at address 0,
// timestamp word at address 1) on request and compares both against
// build-time expected values.
// Ports:
//   clock, reset_n   : clock and asynchronous active-low reset
//   start            : single-cycle request to run a check sequence
//   avm_address      : 0 = ID word, 1 = timestamp word
//   avm_read         : read request
//   avm_waitrequest  : slave stall
//   avm_readdata     : read data
//   busy             : sequence in progress
//   done             : one-cycle pulse at the end of a sequence
//   id_match         : captured ID equals EXPECTED_ID
//   ts_match         : captured timestamp equals EXPECTED_TIMESTAMP
//   error_timeout    : last sequence aborted on a waitrequest timeout
//   id_value         : captured ID word
//   ts_value         : captured timestamp word
// ---------------------------------------------------------------------------
module sysid_reader_master
   import sysid_pkg::*;
#(
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1671595929,
   parameter int unsigned             READ_LATENCY       = 0,
   parameter int unsigned             TIMEOUT_CYCLES     = 255
)(
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   output logic                    avm_address,
   output logic                    avm_read,
   input  logic                    avm_waitrequest,
   input  logic [SYSID_DATA_W-1:0] avm_readdata,
   output logic                    busy,
   output logic                    done,
   output logic                    id_match,
   output logic                    ts_match,
   output logic                    error_timeout,
   output logic [SYSID_DATA_W-1:0] id_value,
   output logic [SYSID_DATA_W-1:0] ts_value
);

   localparam logic [SYSID_CNT_W-1:0] LAT_TC = SYSID_CNT_W'(READ_LATENCY);
   localparam logic [SYSID_CNT_W-1:0] TO_TC  = SYSID_CNT_W'(TIMEOUT_CYCLES);
   localparam logic                   LAT_EN = (READ_LATENCY != 0);

   sysid_rd_state_t state_q, state_d;

   logic                   tmr_clear;
   logic                   tmr_load;
   logic                   tmr_incr;
   logic [SYSID_CNT_W-1:0] tmr_terminal;
   logic                   tmr_hit;

   logic clear_status;
   logic capture_id;
   logic capture_ts;
   logic set_timeout;

   // The accept-cycle load of 1 makes the first latency cycle count as 1,
   // so the capture lands exactly READ_LATENCY cycles after accept.
   sysid_stall_timer u_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (tmr_clear),
      .load       (tmr_load),
      .load_value (SYSID_CNT_W'(1)),
      .incr       (tmr_incr),
      .terminal   (tmr_terminal),
      .hit        (tmr_hit)
   );

   // State register; an asynchronous reset returns straight to IDLE, which
   // also drops avm_read immediately since it is decoded from the state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and bus-control decode. In a request state the timeout
   // check takes priority: once the stall count reaches TIMEOUT_CYCLES the
   // read is withdrawn in that cycle and the sequence finishes.
   always_comb begin
      state_d      = state_q;
      avm_read     = 1'b0;
      avm_address  = SYSID_ADDR_ID;
      tmr_clear    = 1'b0;
      tmr_load     = 1'b0;
      tmr_incr     = 1'b0;
      tmr_terminal = TO_TC;
      clear_status = 1'b0;
      capture_id   = 1'b0;
      capture_ts   = 1'b0;
      set_timeout  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               clear_status = 1'b1;
               tmr_clear    = 1'b1;
               state_d      = REQ_ID;
            end
         end

         REQ_ID: begin
            avm_address = SYSID_ADDR_ID;
            if (tmr_hit) begin
               set_timeout = 1'b1;
               tmr_clear   = 1'b1;
               state_d     = FIN;
            end else begin
               avm_read = 1'b1;
               if (avm_waitrequest) begin
                  tmr_incr = 1'b1;
               end else if (!LAT_EN) begin
                  capture_id = 1'b1;
                  tmr_clear  = 1'b1;
                  state_d    = REQ_TS;
               end else begin
                  tmr_load = 1'b1;
                  state_d  = LAT_ID;
               end
            end
         end

         LAT_ID: begin
            tmr_terminal = LAT_TC;
            tmr_incr     = 1'b1;
            if (tmr_hit) begin
               capture_id = 1'b1;
               tmr_clear  = 1'b1;
               state_d    = REQ_TS;
            end
         end

         REQ_TS: begin
            avm_address = SYSID_ADDR_TS;
            if (tmr_hit) begin
               set_timeout = 1'b1;
               tmr_clear   = 1'b1;
               state_d     = FIN;
            end else begin
               avm_read = 1'b1;
               if (avm_waitrequest) begin
                  tmr_incr = 1'b1;
               end else if (!LAT_EN) begin
                  capture_ts = 1'b1;
                  tmr_clear  = 1'b1;
                  state_d    = FIN;
               end else begin
                  tmr_load = 1'b1;
                  state_d  = LAT_TS;
               end
            end
         end

         LAT_TS: begin
            tmr_terminal = LAT_TC;
            tmr_incr     = 1'b1;
            if (tmr_hit) begin
               capture_ts = 1'b1;
               tmr_clear  = 1'b1;
               state_d    = FIN;
            end
         end

         FIN: begin
            tmr_clear = 1'b1;
            state_d   = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Captured words and status flags. The match flags are registered on the
   // timestamp capture so they are valid during FIN alongside done; a timeout
   // never reaches that capture, so the flags stay cleared.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         id_value      <= '0;
         ts_value      <= '0;
         id_match      <= 1'b0;
         ts_match      <= 1'b0;
         error_timeout <= 1'b0;
      end else begin
         if (clear_status) begin
            id_match      <= 1'b0;
            ts_match      <= 1'b0;
            error_timeout <= 1'b0;
         end
         if (capture_id) begin
            id_value <= avm_readdata;
         end
         if (capture_ts) begin
            ts_value <= avm_readdata;
            ts_match <= (avm_readdata == EXPECTED_TIMESTAMP);
            id_match <= (id_value == EXPECTED_ID);
         end
         if (set_timeout) begin
            error_timeout <= 1'b1;
         end
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == FIN);

endmodule : sysid_reader_master
